// File: rtl/pipeline_hazard_ctrl.sv
// Decode-side interlock: shadows in-flight destinations, withholds d_pass on RAW/PC hazards,
// and counts stall cycles. Define HAZARD_FLAGS_EN to also interlock flag readers on flag writers.
module pipeline_hazard_ctrl #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_rs1_use,
    input  logic             d_rs2_use,
    input  logic [4:0]       d_wa1,
    input  logic [4:0]       d_wa2,
    input  logic             d_we1,
    input  logic             d_we2,
    input  logic             d_is_cond,
    input  logic [3:0]       d_write_flags,
    input  logic             d_pc_write,
    output logic             d_pass,
    output logic             d_pcincr,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_we1;
    logic [DEPTH-1:0] slot_we2;
    logic [4:0]       slot_wa1 [DEPTH];
    logic [4:0]       slot_wa2 [DEPTH];
`ifdef HAZARD_FLAGS_EN
    logic [DEPTH-1:0] slot_fwr;
`endif
    logic [2:0]       pc_pend;
    logic             raw;
    logic             flag_haz;
    logic             pass_int;

    always_comb begin
        // NOTE: default before the loop so every path assigns raw and no latch is inferred.
        raw = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_valid[k]) begin
                if (d_rs1_use && ((slot_we1[k] && slot_wa1[k] == d_rs1) ||
                                  (slot_we2[k] && slot_wa2[k] == d_rs1)))
                    raw = 1'b1;
                if (d_rs2_use && ((slot_we1[k] && slot_wa1[k] == d_rs2) ||
                                  (slot_we2[k] && slot_wa2[k] == d_rs2)))
                    raw = 1'b1;
            end
        end
    end

`ifdef HAZARD_FLAGS_EN
    assign flag_haz = d_valid & d_is_cond & (|(slot_valid & slot_fwr));
`else
    // Flag correctness is left to the ALU bypass in this build.
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{d_is_cond, d_write_flags};
    assign flag_haz = 1'b0;
`endif

    assign pass_int = d_valid & ~raw & ~flag_haz & (pc_pend == 3'd0);
    assign d_pass   = ~rst & pass_int;
    assign d_pcincr = rst | ((pc_pend == 3'd0) & (pass_int | ~d_valid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid   <= '0;
            pc_pend      <= 3'd0;
            stall_cycles <= '0;
        end else begin
            // NOTE: non-blocking so every slot samples its neighbour's pre-edge value.
            for (int k = DEPTH - 1; k > 0; k--)
                slot_valid[k] <= slot_valid[k-1];
            slot_valid[0] <= pass_int;

            if (pass_int && d_pc_write)
                pc_pend <= 3'(DEPTH);
            else if (pc_pend != 3'd0)
                pc_pend <= pc_pend - 3'd1;

            if (d_valid && !pass_int && stall_cycles != {CNT_W{1'b1}})
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // NOTE: payload is only meaningful under slot_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
            slot_wa1[k] <= slot_wa1[k-1];
            slot_wa2[k] <= slot_wa2[k-1];
            slot_we1[k] <= slot_we1[k-1];
            slot_we2[k] <= slot_we2[k-1];
`ifdef HAZARD_FLAGS_EN
            slot_fwr[k] <= slot_fwr[k-1];
`endif
        end
        slot_wa1[0] <= d_wa1;
        slot_wa2[0] <= d_wa2;
        slot_we1[0] <= d_we1;
        slot_we2[0] <= d_we2;
`ifdef HAZARD_FLAGS_EN
        slot_fwr[0] <= |d_write_flags;
`endif
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (DEPTH=3, narrow stall counter to reach saturation).
// Expectations are queued when a step is driven and popped when the outputs are sampled.
module tb_pipeline_hazard_ctrl;

    localparam int DEPTH = 3;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       rs1_use;
        logic [4:0] rs2;
        logic       rs2_use;
        logic [4:0] wa1;
        logic       we1;
        logic [4:0] wa2;
        logic       we2;
        logic       is_cond;
        logic [3:0] wflags;
        logic       pc_write;
    } instr_t;

    typedef struct {
        logic             pass;
        logic             pcincr;
        logic [CNT_W-1:0] stall;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             d_valid;
    logic [4:0]       d_rs1, d_rs2, d_wa1, d_wa2;
    logic             d_rs1_use, d_rs2_use, d_we1, d_we2;
    logic             d_is_cond;
    logic [3:0]       d_write_flags;
    logic             d_pc_write;
    logic             d_pass, d_pcincr;
    logic [CNT_W-1:0] stall_cycles;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] s_model = '0;

    pipeline_hazard_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_valid      (d_valid),
        .d_rs1        (d_rs1),
        .d_rs2        (d_rs2),
        .d_rs1_use    (d_rs1_use),
        .d_rs2_use    (d_rs2_use),
        .d_wa1        (d_wa1),
        .d_wa2        (d_wa2),
        .d_we1        (d_we1),
        .d_we2        (d_we2),
        .d_is_cond    (d_is_cond),
        .d_write_flags(d_write_flags),
        .d_pc_write   (d_pc_write),
        .d_pass       (d_pass),
        .d_pcincr     (d_pcincr),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic instr_t alu(input logic [4:0] wa, input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t t;
        t          = '0;
        t.valid    = 1'b1;
        t.wa1      = wa;
        t.we1      = 1'b1;
        t.rs1      = rs1;
        t.rs1_use  = 1'b1;
        t.rs2      = rs2;
        t.rs2_use  = 1'b1;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        d_valid       = t.valid;
        d_rs1         = t.rs1;
        d_rs1_use     = t.rs1_use;
        d_rs2         = t.rs2;
        d_rs2_use     = t.rs2_use;
        d_wa1         = t.wa1;
        d_we1         = t.we1;
        d_wa2         = t.wa2;
        d_we2         = t.we2;
        d_is_cond     = t.is_cond;
        d_write_flags = t.wflags;
        d_pc_write    = t.pc_write;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic ep, input logic epc, input logic [CNT_W-1:0] es);
        exp_t e;
        e.pass   = ep;
        e.pcincr = epc;
        e.stall  = es;
        sb.push_back(e);
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".d_pass"},       32'(d_pass),       32'(e.pass));
            check({tag, ".d_pcincr"},     32'(d_pcincr),     32'(e.pcincr));
            check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.stall));
        end
    endtask

    // One decode cycle: drive, queue expectation, sample mid-cycle, advance past the next edge.
    task automatic present(input instr_t t, input logic ep, input logic epc, input string tag);
        drive(t);
        push_exp(ep, epc, s_model);
        #3;
        compare_head(tag);
        if (t.valid && !ep && s_model != {CNT_W{1'b1}})
            s_model = s_model + 1'b1;
        @(posedge clk);
        #1;
    endtask

    instr_t ins;
    instr_t bubble;

    initial begin
        bubble = '0;
        rst = 1'b1;
        drive(bubble);
        #3;
        push_exp(1'b0, 1'b1, '0);
        compare_head("reset_idle");
        drive(alu(1, 2, 3));
        #1;
        push_exp(1'b0, 1'b1, '0);
        compare_head("reset_forced");
        @(posedge clk);
        #1;
        rst = 1'b0;

        present(bubble, 1'b0, 1'b1, "idle_invalid");

        // independent stream
        present(alu(1, 3, 4), 1'b1, 1'b1, "indep_a");
        present(alu(2, 3, 4), 1'b1, 1'b1, "indep_b");

        // back-to-back RAW through rs2: three stall cycles
        present(alu(5, 8, 9), 1'b1, 1'b1, "raw_writer");
        for (int i = 0; i < 3; i++) present(alu(6, 10, 5), 1'b0, 1'b0, "raw_stall");
        present(alu(6, 10, 5), 1'b1, 1'b1, "raw_pass");

        // distance one: two stalls
        present(alu(7, 11, 12), 1'b1, 1'b1, "dist1_writer");
        present(alu(13, 14, 15), 1'b1, 1'b1, "dist1_indep");
        for (int i = 0; i < 2; i++) present(alu(20, 7, 16), 1'b0, 1'b0, "dist1_stall");
        present(alu(20, 7, 16), 1'b1, 1'b1, "dist1_pass");

        // distance two: one stall
        present(alu(22, 1, 2), 1'b1, 1'b1, "dist2_writer");
        present(alu(23, 1, 2), 1'b1, 1'b1, "dist2_indep_a");
        present(alu(24, 1, 2), 1'b1, 1'b1, "dist2_indep_b");
        present(alu(25, 3, 22), 1'b0, 1'b0, "dist2_stall");
        present(alu(25, 3, 22), 1'b1, 1'b1, "dist2_pass");

        // register 0 is tracked; unused rs1 ignored; write port 2 tracked
        present(alu(0, 1, 2), 1'b1, 1'b1, "r0_writer");
        ins = alu(26, 25, 0);
        ins.we1 = 1'b0;
        ins.wa2 = 5'd26;
        ins.we2 = 1'b1;
        ins.rs1_use = 1'b0;
        for (int i = 0; i < 3; i++) present(ins, 1'b0, 1'b0, "r0_stall");
        present(ins, 1'b1, 1'b1, "r0_pass");
        ins = alu(27, 26, 1);
        ins.rs1_use = 1'b0;
        present(ins, 1'b1, 1'b1, "unused_rs1");
        for (int i = 0; i < 2; i++) present(alu(28, 3, 26), 1'b0, 1'b0, "wa2_stall");
        present(alu(28, 3, 26), 1'b1, 1'b1, "wa2_pass");

        // PC write: three frozen cycles, then fetch resumes
        ins = alu(0, 1, 2);
        ins.we1 = 1'b0;
        ins.pc_write = 1'b1;
        present(ins, 1'b1, 1'b1, "pc_writer");
        present(bubble, 1'b0, 1'b0, "pc_hold_1");
        present(bubble, 1'b0, 1'b0, "pc_hold_2");
        present(alu(29, 3, 4), 1'b0, 1'b0, "pc_hold_3");
        present(alu(29, 3, 4), 1'b1, 1'b1, "pc_resume");

        // flag writer followed by a conditional reader
        ins = alu(30, 1, 2);
        ins.wflags = 4'b0001;
        present(ins, 1'b1, 1'b1, "flag_writer");
        ins = alu(31, 3, 4);
        ins.is_cond = 1'b1;
`ifdef HAZARD_FLAGS_EN
        for (int i = 0; i < 3; i++) present(ins, 1'b0, 1'b0, "flag_stall");
`endif
        present(ins, 1'b1, 1'b1, "flag_pass");
        present(bubble, 1'b0, 1'b1, "idle_after_flag");

        // reset in the second cycle of a RAW stall
        present(alu(5, 1, 2), 1'b1, 1'b1, "rst_writer");
        present(alu(6, 5, 3), 1'b0, 1'b0, "rst_stall_1");
        drive(alu(6, 5, 3));
        push_exp(1'b0, 1'b0, s_model);
        #3;
        compare_head("rst_stall_2");
        rst = 1'b1;
        #1;
        push_exp(1'b0, 1'b1, '0);
        compare_head("rst_mid_stall");
        s_model = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        present(alu(6, 5, 3), 1'b1, 1'b1, "rst_consumer_pass");

        // repeated RAW stalls drive the counter into saturation
        for (int r = 0; r < 6; r++) begin
            present(alu(10, 1, 2), 1'b1, 1'b1, "sat_writer");
            for (int i = 0; i < 3; i++) present(alu(11, 10, 3), 1'b0, 1'b0, "sat_stall");
            present(alu(11, 10, 3), 1'b1, 1'b1, "sat_pass");
        end
        drive(bubble);
        push_exp(1'b0, 1'b1, {CNT_W{1'b1}});
        #3;
        compare_head("sat_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
